// File: rtl/sync_ram_arb_pkg.sv
// Shared types for the syncRAM arbiter: FSM states, the registered command and default widths.
// Round-robin arbitration is selected by defining SYNC_RAM_ARB_ROUND_ROBIN_EN.
package sync_ram_arb_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 8;
    localparam int MAX_REQ    = 8;
    localparam int OWNER_W    = 3;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_e;

    // Sized for the default RAM; ADDR_W/DATA_W of the top must not exceed these.
    typedef struct packed {
        logic                  we;
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] data;
        logic [OWNER_W-1:0]    owner;
    } arb_cmd_t;

    function automatic logic [OWNER_W-1:0] onehot_idx(input logic [MAX_REQ-1:0] v);
        onehot_idx = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (v[i]) onehot_idx = OWNER_W'(i);
        end
    endfunction

endpackage

// File: rtl/sync_ram_arbiter_rr_arbiter.sv
// One-hot grant from a request vector. Round-robin when SYNC_RAM_ARB_ROUND_ROBIN_EN is
// defined (search starts after the last grant), otherwise fixed priority with index 0 highest.
module rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant
);

`ifdef SYNC_RAM_ARB_ROUND_ROBIN_EN
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] win;
    logic [PTR_W:0]   idx;
    logic             found;

    // NOTE: every variable written here gets a default first, so no path leaves one unassigned (no latch).
    always_comb begin
        grant = '0;
        win   = ptr;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = {1'b0, ptr} + (PTR_W+1)'(i);
            if (idx >= (PTR_W+1)'(NUM_REQ)) idx = idx - (PTR_W+1)'(NUM_REQ);
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                win        = idx[PTR_W-1:0];
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= (win == PTR_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
        end
    end
`else
    logic unused_rr;
    assign unused_rr = ^{clk, rst_n, advance};

    always_comb begin
        grant = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                grant    = '0;
                grant[i] = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/sync_ram_arbiter.sv
// Shares one syncRAM between NUM_REQ valid/ready requesters; one access in flight at a time.
// Arbitration policy is chosen by SYNC_RAM_ARB_ROUND_ROBIN_EN (see rr_arbiter).
module sync_ram_arbiter
    import sync_ram_arb_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int RD_LATENCY = 1
) (
    input  logic                      Clk,
    input  logic                      Rst_n,
    input  logic [NUM_REQ-1:0]        ReqValid,
    output logic [NUM_REQ-1:0]        ReqReady,
    input  logic [NUM_REQ-1:0]        ReqWE,
    input  logic [NUM_REQ*ADDR_W-1:0] ReqAddr,
    input  logic [NUM_REQ*DATA_W-1:0] ReqData,
    output logic [NUM_REQ-1:0]        RspValid,
    output logic [DATA_W-1:0]         RspData,
    output logic                      RamCS,
    output logic                      RamWE,
    output logic                      RamRD,
    output logic [ADDR_W-1:0]         RamAddr,
    output logic [DATA_W-1:0]         RamDataIn,
    input  logic [DATA_W-1:0]         RamDataOut
);

    localparam int               CNT_W    = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_LATENCY - 1);

    arb_state_e         state, state_nx;
    arb_cmd_t           cmd;
    logic [CNT_W-1:0]   cnt;
    logic [NUM_REQ-1:0] grant;
    logic               accept;
    logic               we_sel;
    logic [ADDR_W-1:0]  addr_sel;
    logic [DATA_W-1:0]  data_sel;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .clk     (Clk),
        .rst_n   (Rst_n),
        .req     (ReqValid),
        .advance (accept),
        .grant   (grant)
    );

    // Gated by Rst_n so nothing is accepted while reset is being held.
    assign accept   = Rst_n && (state == IDLE) && (|ReqValid);
    assign ReqReady = accept ? grant : '0;

    always_comb begin
        we_sel   = 1'b0;
        addr_sel = '0;
        data_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                we_sel   = ReqWE[i];
                addr_sel = ReqAddr[i*ADDR_W +: ADDR_W];
                data_sel = ReqData[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_nx  = state;
        RamCS     = 1'b0;
        RamWE     = 1'b0;
        RamRD     = 1'b0;
        RamAddr   = '0;
        RamDataIn = '0;
        RspValid  = '0;
        case (state)
            IDLE:  if (accept) state_nx = ISSUE;
            ISSUE: begin
                RamCS     = 1'b1;
                RamWE     = cmd.we;
                RamRD     = ~cmd.we;
                RamAddr   = cmd.addr[ADDR_W-1:0];
                RamDataIn = cmd.data[DATA_W-1:0];
                state_nx  = cmd.we ? IDLE : WAIT;
            end
            // RAM data is valid in the last WAIT cycle and captured on its closing edge.
            WAIT:  if (cnt == CNT_LAST) state_nx = RESP;
            RESP: begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    RspValid[i] = (cmd.owner == OWNER_W'(i));
                end
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state   <= IDLE;
            cmd     <= '0;
            cnt     <= '0;
            RspData <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                cmd <= '{we:    we_sel,
                         addr:  DEF_ADDR_W'(addr_sel),
                         data:  DEF_DATA_W'(data_sel),
                         owner: onehot_idx(MAX_REQ'(grant))};
            end
            if (state == WAIT) begin
                cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
                if (cnt == CNT_LAST) RspData <= RamDataOut;
            end
        end
    end

endmodule

// File: tb/tb_sync_ram_arbiter.sv
// Directed bench: two arbiters (RD_LATENCY 1 and 3), each with a behavioural syncRAM model.
// Expected grant order follows SYNC_RAM_ARB_ROUND_ROBIN_EN.
module tb_sync_ram_arbiter;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid, req_ready, req_we, rsp_valid;
    logic [15:0] req_addr, req_data;
    logic [7:0]  rsp_data, ram_addr, ram_din, ram_dout;
    logic        ram_cs, ram_we, ram_rd;

    logic [1:0]  req_valid3, req_ready3, req_we3, rsp_valid3;
    logic [15:0] req_addr3, req_data3;
    logic [7:0]  rsp_data3, ram_addr3, ram_din3, ram_dout3;
    logic        ram_cs3, ram_we3, ram_rd3;

    int n_checks = 0;
    int n_errors = 0;

    sync_ram_arbiter #(.NUM_REQ(2), .ADDR_W(8), .DATA_W(8), .RD_LATENCY(1)) dut (
        .Clk(clk), .Rst_n(rst_n), .ReqValid(req_valid), .ReqReady(req_ready), .ReqWE(req_we),
        .ReqAddr(req_addr), .ReqData(req_data), .RspValid(rsp_valid), .RspData(rsp_data),
        .RamCS(ram_cs), .RamWE(ram_we), .RamRD(ram_rd), .RamAddr(ram_addr),
        .RamDataIn(ram_din), .RamDataOut(ram_dout)
    );

    sync_ram_arbiter #(.NUM_REQ(2), .ADDR_W(8), .DATA_W(8), .RD_LATENCY(3)) dut3 (
        .Clk(clk), .Rst_n(rst_n), .ReqValid(req_valid3), .ReqReady(req_ready3), .ReqWE(req_we3),
        .ReqAddr(req_addr3), .ReqData(req_data3), .RspValid(rsp_valid3), .RspData(rsp_data3),
        .RamCS(ram_cs3), .RamWE(ram_we3), .RamRD(ram_rd3), .RamAddr(ram_addr3),
        .RamDataIn(ram_din3), .RamDataOut(ram_dout3)
    );

    // RAM models: read data appears for one cycle only, RD_LATENCY edges after the RD edge.
    logic [7:0] mem1 [256];
    logic [7:0] mem3 [256];
    logic [7:0] pipe3 [3];

    always @(posedge clk) begin
        if (ram_cs && ram_we) mem1[ram_addr] <= ram_din;
        ram_dout <= (ram_cs && ram_rd) ? mem1[ram_addr] : 8'hEE;
        if (ram_cs3 && ram_we3) mem3[ram_addr3] <= ram_din3;
        pipe3[0] <= (ram_cs3 && ram_rd3) ? mem3[ram_addr3] : 8'hEE;
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    assign ram_dout3 = pipe3[2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input int r, input string name);
        int n = 0;
        while (!req_ready[r] && n < 20) begin
            step();
            #1;
            n++;
        end
        check(name, 32'(req_ready[r]), 32'd1);
    endtask

    task automatic wr1(input int r, input logic [7:0] a, input logic [7:0] d);
        req_valid = '0;
        req_valid[r] = 1'b1;
        req_we[r] = 1'b1;
        req_addr[r*8 +: 8] = a;
        req_data[r*8 +: 8] = d;
        #1;
        wait_ready(r, "wr_grant");
        step();
        req_valid = '0;
        step();
    endtask

    task automatic rd1(input int r, input logic [7:0] a, input logic [7:0] exp_d, input string name);
        int lat;
        req_valid = '0;
        req_valid[r] = 1'b1;
        req_we[r] = 1'b0;
        req_addr[r*8 +: 8] = a;
        #1;
        wait_ready(r, "rd_grant");
        step();
        req_valid = '0;
        lat = 1;
        while (!rsp_valid[r] && lat < 12) begin
            step();
            lat++;
        end
        check({name, "_latency"}, 32'(lat), 32'd3);
        check({name, "_data"}, 32'(rsp_data), 32'(exp_d));
        step();
    endtask

    typedef struct {
        logic [1:0]  valid;
        logic [1:0]  we;
        logic [7:0]  a0;
        logic [7:0]  d0;
        logic [30:0] exp;   // {ready, cs, we, rd, addr, din, rsp_valid, rsp_data}
    } vec_t;

    vec_t vecs [7];
    logic gseq [4];

    initial begin
        int n;
        int cyc;
        int lat;
        vecs[0] = '{2'b01, 2'b01, 8'h03, 8'h06, {2'b01, 3'b000, 8'h00, 8'h00, 2'b00, 8'h00}};
        vecs[1] = '{2'b00, 2'b00, 8'h03, 8'h06, {2'b00, 3'b110, 8'h03, 8'h06, 2'b00, 8'h00}};
        vecs[2] = '{2'b01, 2'b00, 8'h03, 8'h00, {2'b01, 3'b000, 8'h00, 8'h00, 2'b00, 8'h00}};
        vecs[3] = '{2'b00, 2'b00, 8'h03, 8'h00, {2'b00, 3'b101, 8'h03, 8'h00, 2'b00, 8'h00}};
        vecs[4] = '{2'b00, 2'b00, 8'h03, 8'h00, {2'b00, 3'b000, 8'h00, 8'h00, 2'b00, 8'h00}};
        vecs[5] = '{2'b00, 2'b00, 8'h03, 8'h00, {2'b00, 3'b000, 8'h00, 8'h00, 2'b01, 8'h06}};
        vecs[6] = '{2'b00, 2'b00, 8'h03, 8'h00, {2'b00, 3'b000, 8'h00, 8'h00, 2'b00, 8'h06}};

        rst_n = 1'b0;
        req_valid = 2'b11; req_we = '0; req_addr = '0; req_data = '0;
        req_valid3 = '0; req_we3 = '0; req_addr3 = '0; req_data3 = '0;

        for (int i = 0; i < 3; i++) begin
            step();
            #1;
            check("reset_ready", 32'(req_ready), 32'd0);
            check("reset_cs", 32'(ram_cs), 32'd0);
            check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        end
        check("reset_rsp_data", 32'(rsp_data), 32'd0);

        rst_n = 1'b1;
        for (int i = 0; i < 7; i++) begin
            req_valid = vecs[i].valid;
            req_we = vecs[i].we;
            req_addr[7:0] = vecs[i].a0;
            req_data[7:0] = vecs[i].d0;
            #1;
            check($sformatf("vec%0d", i),
                  32'({req_ready, ram_cs, ram_we, ram_rd, ram_addr, ram_din, rsp_valid, rsp_data}),
                  32'(vecs[i].exp));
            step();
        end

        rst_n = 1'b0;
        step();
        rst_n = 1'b1;

        req_valid = 2'b11; req_we = 2'b11;
        req_addr = {8'h04, 8'h02}; req_data = {8'h12, 8'h10};
        #1;
        n = 0;
        cyc = 0;
        while (n < 4 && cyc < 40) begin
            if (req_ready != 2'b00) begin
                gseq[n] = req_ready[1];
                n++;
            end
            step();
            #1;
            cyc++;
        end
        check("contention_grants", 32'(n), 32'd4);
        for (int k = 0; k < 4; k++) begin
`ifdef SYNC_RAM_ARB_ROUND_ROBIN_EN
            check($sformatf("rr_grant%0d", k), 32'(gseq[k]), 32'(k % 2));
`else
            check($sformatf("fixed_grant%0d", k), 32'(gseq[k]), 32'd0);
`endif
        end
        req_valid = 2'b10;
        #1;
        wait_ready(1, "late_grant_req1");
        step();
        req_valid = '0;
        step();

        rd1(0, 8'h02, 8'h10, "readback_02");
        rd1(1, 8'h04, 8'h12, "readback_04");
        wr1(0, 8'h01, 8'h01);
        rd1(0, 8'h01, 8'h01, "lat1_read_01");

        req_valid = 2'b01; req_we = 2'b00; req_addr[7:0] = 8'h02;
        #1;
        wait_ready(0, "midrst_grant");
        step();
        req_valid = '0;
        step();
        rst_n = 1'b0;
        step();
        #1;
        check("midrst_cs", 32'(ram_cs), 32'd0);
        check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("midrst_rsp_data", 32'(rsp_data), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            #1;
            check("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
        end
        req_valid = 2'b01;
        #1;
        check("post_rst_idle_ready", 32'(req_ready), 32'd1);
        req_valid = '0;
        step();

        req_valid3 = 2'b01; req_we3 = 2'b01; req_addr3 = 16'h0001; req_data3 = 16'h0001;
        #1;
        n = 0;
        while (!req_ready3[0] && n < 20) begin
            step();
            #1;
            n++;
        end
        check("lat3_wr_grant", 32'(req_ready3[0]), 32'd1);
        step();
        req_valid3 = '0;
        step();
        req_valid3 = 2'b01; req_we3 = 2'b00;
        #1;
        n = 0;
        while (!req_ready3[0] && n < 20) begin
            step();
            #1;
            n++;
        end
        check("lat3_rd_grant", 32'(req_ready3[0]), 32'd1);
        step();
        req_valid3 = '0;
        lat = 1;
        while (!rsp_valid3[0] && lat < 12) begin
            step();
            lat++;
        end
        check("lat3_latency", 32'(lat), 32'd5);
        check("lat3_data", 32'(rsp_data3), 32'h01);
        step();
        check("lat3_pulse_one_cycle", 32'(rsp_valid3), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
